// File: rtl/prio_pkg.sv
// Shared constants and helpers for the priority encoder / arbiter slice.
package prio_pkg;

    // Selection policies for the arbiter.
    localparam int PRIO_FIXED = 0;
    localparam int PRIO_RR    = 1;

    // Number of bits needed to hold the values 0..value-1 (value >= 2).
    function automatic int clog2(input int value);
        int result;
        int rem;
        result = 0;
        rem    = value - 1;
        while (rem > 0) begin
            result = result + 1;
            rem    = rem >>> 1;
        end
        return result;
    endfunction

endpackage

// File: rtl/prio_pick.sv
// Combinational picker: rotates the eligible vector by the search base using a
// doubled copy, then finds the highest set bit. Fixed mode uses base 0, so the
// highest index wins; round-robin uses rr_ptr, so rr_ptr-1 ranks highest and
// rr_ptr itself ranks lowest.
module prio_pick
    import prio_pkg::*;
#(
    parameter  int N       = 8,
    parameter  int RR_MODE = PRIO_FIXED,
    localparam int W       = clog2(N)
) (
    input  logic [N-1:0] elig,
    input  logic [W-1:0] rr_ptr,
    output logic         any,
    output logic [W-1:0] idx
);

    localparam logic [W:0] N_L = (W+1)'(N);

    logic [2*N-1:0] dbl_s;
    logic [N-1:0]   rot_s;
    logic [W-1:0]   base_s;
    logic [W-1:0]   off_s;
    logic [W:0]     sum_s;

    assign base_s = (RR_MODE == PRIO_RR) ? rr_ptr : {W{1'b0}};
    assign dbl_s  = {elig, elig};
    assign rot_s  = dbl_s[base_s +: N];
    assign any    = |elig;

    // Find the highest set position of the rotated vector; later hits override.
    always_comb begin
        off_s = {W{1'b0}};
        for (int k = 0; k < N; k++) begin
            off_s = rot_s[k] ? W'(k) : off_s;
        end
    end

    // Undo the rotation modulo N so codes >= N never appear.
    assign sum_s = {1'b0, base_s} + {1'b0, off_s};
    assign idx   = (sum_s >= N_L) ? W'(sum_s - N_L) : sum_s[W-1:0];

endmodule

// File: rtl/prio_encode_arb.sv
// Clocked priority encoder / arbiter: captures request assert edges into a
// pending register, grants one eligible line at a time on a valid/ready code
// output and keeps registered GS/EO cascade flags.
module prio_encode_arb
    import prio_pkg::*;
#(
    parameter  int N          = 8,
    parameter  int ACTIVE_LOW = 1,
    parameter  int RR_MODE    = PRIO_FIXED,
    localparam int W          = clog2(N)
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         ei_n,
    input  logic [N-1:0] req,
    input  logic [N-1:0] mask,
    input  logic         code_ready,
    output logic         code_valid,
    output logic [W-1:0] code,
    output logic         gs_n,
    output logic         eo_n,
    output logic [N-1:0] pending
);

    logic [N-1:0] act_s;
    logic [N-1:0] set_s;
    logic [N-1:0] clr_s;
    logic [N-1:0] elig_next_s;
    logic         accept_s;
    logic         slot_free_s;
    logic         pick_any_s;
    logic [W-1:0] pick_idx_s;

    logic [N-1:0] req_q_r;
    logic [N-1:0] pending_r;
    logic         armed_r;
    logic         code_valid_r;
    logic [W-1:0] code_r;
    logic         gs_n_r;
    logic         eo_n_r;
    logic [W-1:0] rr_ptr_r;

    assign act_s       = (ACTIVE_LOW != 0) ? ~req : req;
    assign accept_s    = code_valid_r & code_ready;
    assign slot_free_s = ~code_valid_r | code_ready;

    // armed_r suppresses capture on the first edge after reset, when req_q is
    // still at its inactive reset value and a held request would look like an edge.
    assign set_s = armed_r ? (act_s & ~req_q_r) : {N{1'b0}};
    assign clr_s = accept_s ? ({{(N-1){1'b0}}, 1'b1} << code_r) : {N{1'b0}};

    // Excluding the bit being accepted keeps a back-to-back grant from repeating it.
    assign elig_next_s = pending_r & ~mask & ~clr_s;

    prio_pick #(
        .N       (N),
        .RR_MODE (RR_MODE)
    ) u_pick (
        .elig   (elig_next_s),
        .rr_ptr (rr_ptr_r),
        .any    (pick_any_s),
        .idx    (pick_idx_s)
    );

    // Edge capture and pending bookkeeping; a same-cycle set beats the clear.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            armed_r   <= 1'b0;
            req_q_r   <= {N{1'b0}};
            pending_r <= {N{1'b0}};
        end else begin
            armed_r   <= 1'b1;
            req_q_r   <= act_s;
            pending_r <= (pending_r & ~clr_s) | set_s;
        end
    end

    // Output slot, round-robin pointer and cascade flags.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            code_valid_r <= 1'b0;
            code_r       <= {W{1'b0}};
            gs_n_r       <= 1'b1;
            eo_n_r       <= 1'b1;
            rr_ptr_r     <= W'(N - 1);
        end else begin
            if (accept_s) begin
                rr_ptr_r <= code_r;
            end
            if (slot_free_s && !ei_n && pick_any_s) begin
                code_valid_r <= 1'b1;
                code_r       <= pick_idx_s;
            end else if (accept_s) begin
                code_valid_r <= 1'b0;
            end
            gs_n_r <= ~(~ei_n & pick_any_s);
            eo_n_r <= ~(~ei_n & ~pick_any_s);
        end
    end

    assign code_valid = code_valid_r;
    assign code       = code_r;
    assign gs_n       = gs_n_r;
    assign eo_n       = eo_n_r;
    assign pending    = pending_r;

endmodule
